// File: rtl/seq_pattern_detector.sv
// Serial detector for a run-time programmable, maskable PAT_W-bit pattern with a
// match pulse and a stretched y_out. Define MATCH_COUNT_EN to add a saturating match_count port.
module seq_pattern_detector #(
    parameter int               PAT_W     = 4,
    parameter int               HOLD      = 2,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] PAT_INIT  = {PAT_W{1'b1}},
    parameter logic [PAT_W-1:0] MASK_INIT = {PAT_W{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             x_in,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             overlap,
`ifdef MATCH_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             match_pulse,
    output logic             y_out
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic {FILL, ARMED} state_t;

    state_t           state;
    logic [PAT_W-1:0] hist, hist_n, pat_r, mask_r;
    logic [FW-1:0]    fill, fill_n;
    logic [HW-1:0]    hold_cnt;
    logic             full_n, hit, restart;

    // In ARMED the fill counter already sits at PAT_W, so it only counts while in FILL.
    always_comb begin
        hist_n  = {hist[PAT_W-2:0], x_in};
        fill_n  = (state == ARMED) ? FW'(PAT_W) : fill + 1'b1;
        full_n  = (fill_n == FW'(PAT_W));
        hit     = full_n && (((hist_n ^ pat_r) & mask_r) == '0);
        restart = hit && !overlap;
    end

    assign y_out = (hold_cnt != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            hist        <= '0;
            fill        <= '0;
            hold_cnt    <= '0;
            pat_r       <= PAT_INIT;
            mask_r      <= MASK_INIT;
            match_pulse <= 1'b0;
`ifdef MATCH_COUNT_EN
            match_count <= '0;
`endif
        end else if (load) begin
            state       <= FILL;
            hist        <= '0;
            fill        <= '0;
            hold_cnt    <= '0;
            pat_r       <= pattern;
            mask_r      <= mask;
            match_pulse <= 1'b0;
`ifdef MATCH_COUNT_EN
            match_count <= '0;
`endif
        end else begin
            if (enable) begin
                hist        <= hist_n;
                match_pulse <= hit;
                fill        <= restart ? '0 : fill_n;
                state       <= (restart || !full_n) ? FILL : ARMED;
            end else begin
                match_pulse <= 1'b0;
            end
            // The hold timer runs off the free clock, not the sample enable.
            if (enable && hit)
                hold_cnt <= HW'(HOLD);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
`ifdef MATCH_COUNT_EN
            if (enable && hit && (match_count != {CNT_W{1'b1}}))
                match_count <= match_count + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector (PAT_W=4, HOLD=2; CNT_W=2 when MATCH_COUNT_EN is set).
module tb_seq_pattern_detector;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       x_in = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] mask = '0;
    logic       overlap = 1'b0;
    logic       match_pulse, y_out;
`ifdef MATCH_COUNT_EN
    logic [1:0] match_count;
`endif

    int checks = 0;
    int failures = 0;

    seq_pattern_detector #(
        .PAT_W(4),
`ifdef MATCH_COUNT_EN
        .CNT_W(2),
`endif
        .HOLD(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .x_in(x_in),
        .load(load),
        .pattern(pattern),
        .mask(mask),
        .overlap(overlap),
`ifdef MATCH_COUNT_EN
        .match_count(match_count),
`endif
        .match_pulse(match_pulse),
        .y_out(y_out)
    );

    always #5 clock = ~clock;

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        enable = 1'b1;
        x_in   = b;
        tick();
    endtask

    task automatic idle();
        enable = 1'b0;
        tick();
    endtask

    task automatic load_pat(input logic [3:0] p, input logic [3:0] m, input logic ov);
        enable  = 1'b0;
        load    = 1'b1;
        pattern = p;
        mask    = m;
        overlap = ov;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if (match_pulse !== 1'b0 || y_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: pulse=%b y=%b expected 0 0", match_pulse, y_out);
        end
        #2 reset = 1'b1;
        tick();
        // Default PAT_INIT/MASK_INIT = 1111, non-overlapping.
        overlap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            checks++;
            if (match_pulse !== (i == 3)) begin
                failures++;
                $display("FAIL reset_init_pattern bit%0d: pulse=%b expected %b", i, match_pulse, (i == 3));
            end
        end
        idle();
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1011;
        load_pat(4'b1011, 4'hF, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i]);
            checks++;
            if (match_pulse !== (i == 0) || y_out !== (i == 0)) begin
                failures++;
                $display("FAIL basic bit%0d: pulse=%b y=%b expected %b %b", 3 - i, match_pulse, y_out, (i == 0), (i == 0));
            end
        end
        idle();
        checks++;
        if (match_pulse !== 1'b0 || y_out !== 1'b1) begin
            failures++;
            $display("FAIL basic_hold1: pulse=%b y=%b expected 0 1", match_pulse, y_out);
        end
        idle();
        checks++;
        if (y_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold_end: y=%b expected 0", y_out);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] stream, exp_p, exp_y;
        stream = 7'b1010101;
        for (int ov = 1; ov >= 0; ov--) begin
            load_pat(4'b1010, 4'hF, ov[0]);
            exp_p = (ov == 1) ? 7'b0001010 : 7'b0001000;
            exp_y = (ov == 1) ? 7'b0001111 : 7'b0001100;
            for (int i = 0; i < 7; i++) begin
                send_bit(stream[6-i]);
                checks++;
                if (match_pulse !== exp_p[6-i] || y_out !== exp_y[6-i]) begin
                    failures++;
                    $display("FAIL overlap%0d bit%0d: pulse=%b y=%b expected %b %b", ov, i + 1, match_pulse, y_out, exp_p[6-i], exp_y[6-i]);
                end
            end
            idle();
            idle();
        end
    endtask

    task automatic test_mask();
        logic [3:0] s;
        load_pat(4'b1001, 4'b1001, 1'b0);
        s = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            send_bit(s[i]);
            checks++;
            if (match_pulse !== (i == 0)) begin
                failures++;
                $display("FAIL mask_dontcare bit%0d: pulse=%b expected %b", 3 - i, match_pulse, (i == 0));
            end
        end
        idle();
        load_pat(4'b1001, 4'b1001, 1'b0);
        s = 4'b0111;
        for (int i = 3; i >= 0; i--) begin
            send_bit(s[i]);
            checks++;
            if (match_pulse !== 1'b0) begin
                failures++;
                $display("FAIL mask_miss bit%0d: pulse=%b expected 0", 3 - i, match_pulse);
            end
        end
        idle();
        // All-zero mask: every sample hits once the history is full.
        load_pat(4'b1111, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            checks++;
            if (match_pulse !== (i >= 3)) begin
                failures++;
                $display("FAIL mask_zero bit%0d: pulse=%b expected %b", i, match_pulse, (i >= 3));
            end
        end
        idle();
        idle();
    endtask

    task automatic test_enable_gap();
        load_pat(4'b1011, 4'hF, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b0;
            x_in   = i[0] ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (match_pulse !== 1'b0) begin
                failures++;
                $display("FAIL gap_idle%0d: pulse=%b expected 0", i, match_pulse);
            end
        end
        send_bit(1'b1);
        checks++;
        if (match_pulse !== 1'b0) begin
            failures++;
            $display("FAIL gap_bit3: pulse=%b expected 0", match_pulse);
        end
        send_bit(1'b1);
        checks++;
        if (match_pulse !== 1'b1) begin
            failures++;
            $display("FAIL gap_bit4: pulse=%b expected 1", match_pulse);
        end
        idle();
        idle();
    endtask

    task automatic test_load_priority();
        // Load edge with enable=1, x_in=1: the bit must not enter the history.
        enable  = 1'b1;
        x_in    = 1'b1;
        load    = 1'b1;
        pattern = 4'b1111;
        mask    = 4'hF;
        overlap = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            checks++;
            if (match_pulse !== (i == 3)) begin
                failures++;
                $display("FAIL load_priority bit%0d: pulse=%b expected %b", i, match_pulse, (i == 3));
            end
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        load_pat(4'b0000, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        checks++;
        if (match_pulse !== 1'b1 || y_out !== 1'b1) begin
            failures++;
            $display("FAIL rmid_prematch: pulse=%b y=%b expected 1 1", match_pulse, y_out);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (match_pulse !== 1'b0 || y_out !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async: pulse=%b y=%b expected 0 0", match_pulse, y_out);
        end
        #1 reset = 1'b1;
        // Pattern back to 1111, history discarded: match only on the 4th new one.
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            checks++;
            if (match_pulse !== (i == 3)) begin
                failures++;
                $display("FAIL rmid_after bit%0d: pulse=%b expected %b", i, match_pulse, (i == 3));
            end
        end
        idle();
        idle();
    endtask

    task automatic test_back_to_back();
        int npulse;
        int exp_c;
        npulse = 0;
        load_pat(4'b1111, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            if (match_pulse === 1'b1) npulse++;
            checks++;
            if (match_pulse !== (i >= 3) || y_out !== (i >= 3)) begin
                failures++;
                $display("FAIL b2b bit%0d: pulse=%b y=%b expected %b %b", i, match_pulse, y_out, (i >= 3), (i >= 3));
            end
`ifdef MATCH_COUNT_EN
            exp_c = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
            checks++;
            if (match_count !== 2'(exp_c)) begin
                failures++;
                $display("FAIL count bit%0d: count=%0d expected %0d", i, match_count, exp_c);
            end
`else
            exp_c = 0;
`endif
        end
        checks++;
        if (npulse != 5) begin
            failures++;
            $display("FAIL b2b_total: pulses=%0d expected 5 (last exp_c %0d)", npulse, exp_c);
        end
        load_pat(4'b1111, 4'hF, 1'b1);
        checks++;
        if (match_pulse !== 1'b0 || y_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load_clear: pulse=%b y=%b expected 0 0", match_pulse, y_out);
        end
`ifdef MATCH_COUNT_EN
        checks++;
        if (match_count !== 2'd0) begin
            failures++;
            $display("FAIL count_load_clear: count=%0d expected 0", match_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_mask();
        test_enable_gap();
        test_load_priority();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed-sequence Moore detectors in this design.
- Watches a 1-bit serial stream `x_in` for a run-time programmable, maskable pattern of `PAT_W` bits.
- Supports overlapping or non-overlapping matching.
- Emits a one-cycle match pulse and a stretched level output `y_out` held for `HOLD` cycles.
- Sits between a serial input source and downstream control logic.

Parameters:
- PAT_W, 4, pattern length in bits; legal 2..16.
- HOLD, 2, cycles `y_out` stays high per match; legal 1..15.
- CNT_W, 8, match counter width; used only with MATCH_COUNT_EN.
- PAT_INIT, {PAT_W{1'b1}}, pattern register value after reset.
- MASK_INIT, {PAT_W{1'b1}}, mask register value after reset.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low; clears all state.
- enable, input, 1, `x_in` is sampled only at edges where enable=1.
- x_in, input, 1, serial data bit.
- load, input, 1, synchronous: capture pattern/mask and restart detection.
- pattern, input, PAT_W, new pattern; `pattern[PAT_W-1]` is the first bit received.
- mask, input, PAT_W, per-bit compare enable (1 = compare, 0 = don't care).
- overlap, input, 1, 1 = overlapping matches, 0 = non-overlapping.
- match_pulse, output, 1, one-cycle pulse per detected match.
- y_out, output, 1, stretched match indication.

Behaviour:
Reset (reset=0, asynchronous):
- hist=0, fill=0, hold_cnt=0, state=FILL.
- pat_r=PAT_INIT, mask_r=MASK_INIT.
- match_pulse=0, y_out=0; match_count=0 when MATCH_COUNT_EN is defined.

Registers:
- hist[PAT_W-1:0] shift register; the newest bit enters `hist[0]` and the oldest sits in `hist[PAT_W-1]`.
- fill counter, 0..PAT_W, saturating.
- hold_cnt, 0..HOLD.

Edge priority, highest first: load, then enable, then idle.

load=1:
- pat_r<=pattern, mask_r<=mask.
- hist<=0, fill<=0, hold_cnt<=0, match_pulse<=0, state<=FILL.
- x_in is ignored at this edge, even if enable=1.

enable=1 with load=0:
- hist_n={hist[PAT_W-2:0],x_in}; fill_n=min(fill+1,PAT_W).
- hit = (fill_n==PAT_W) && (((hist_n ^ pat_r) & mask_r)==0).
- If mask_r is all zeros, hit is true on every sampled bit once full.
- hist<=hist_n and match_pulse<=hit.
- fill<=0 if (hit && !overlap); otherwise fill<=fill_n.

enable=0 with load=0:
- hist and fill hold; match_pulse<=0.

State machine (state register is explicit):
- FILL (fill<PAT_W) -> ARMED when fill_n==PAT_W and there is no non-overlap hit.
- ARMED -> FILL on a hit with overlap=0.
- ARMED -> ARMED on a hit with overlap=1, or on any miss.
- The overlap input is sampled at each edge; changing it mid-stream takes effect at the next hit.

Latency:
- match_pulse is high for exactly the one cycle following the edge that sampled the completing bit.
- With overlap=1 and consecutive enabled bits, match_pulse may be high on consecutive cycles.

y_out:
- y_out = (hold_cnt != 0).
- A hit loads hold_cnt<=HOLD, including a retrigger while y_out is already high.
- Otherwise hold_cnt decrements each clock until 0, regardless of enable.
- A match therefore produces y_out high for HOLD cycles, starting in the same cycle as match_pulse.

Reset mid-operation: all outputs drop immediately (asynchronous), and a partially received pattern is discarded.

Optional Feature:
MATCH_COUNT_EN:
- When defined, adds output port `match_count` [CNT_W-1:0].
- The counter increments on every hit and saturates at 2^CNT_W-1 (no wrap).
- It is cleared by reset and by load.
- When undefined, the port and the counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset, load pattern=4'b1011 mask=4'hF overlap=0, then stream 1,0,1,1 with enable=1 -> match_pulse=1 for one cycle after the 4th sample edge; y_out=1 for exactly 2 cycles.
2. Pattern=4'b1010, stream 1,0,1,0,1,0,1: with overlap=1 -> pulses after bits 4 and 6; with overlap=0 -> only after bit 4.
3. Pattern=4'b1001, mask=4'b1001, stream 1,1,0,1 -> match (middle bits are don't care); stream 0,1,1,1 -> no match.
4. Pattern=4'b1011 with enable=0 for 3 cycles between bits 2 and 3 (x_in toggling during the gap) -> the gap is ignored and the match still occurs after the 4th enabled bit.
5. Feed 3 bits of 4'b1111, then assert reset mid-stream -> y_out and match_pulse are 0 immediately; after release one more 1 gives no match (fill=1).
6. MATCH_COUNT_EN defined, CNT_W=2, overlap=1, pattern 4'b1111, stream 8 ones -> 5 hits, match_count saturates at 3; a subsequent load clears it to 0.
